// File: rtl/program_loader_if.sv
// Program-loader bus: byte receive stream, start control, program-memory
// write port and loader status flags.
interface program_loader_if #(
    parameter int unsigned AB = 11
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          start;
    logic [AB-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we;
    logic          cpu_hold;
    logic          done;
    logic          error;

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  start,
        output mem_addr,
        output mem_data,
        output mem_we,
        output cpu_hold,
        output done,
        output error
    );

    // Host / byte-source side
    modport master (
        output rx_data,
        output rx_valid,
        output start,
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        input  cpu_hold,
        input  done,
        input  error
    );
endinterface

// File: rtl/program_loader.sv
// Serial program loader. Parses SYNC, COUNT_HI, COUNT_LO, COUNT 16-bit words
// (MSB first) and an optional CHK byte, writing each word to program memory
// at consecutive addresses starting from 0. The CPU is held in reset-like hold
// until a load completes.
// Optional feature: define LOADER_CHECKSUM_EN to expect and verify a trailing
// XOR checksum byte (XOR of COUNT_HI, COUNT_LO and all data bytes). Without
// it, CHECK passes straight to DONE and no checksum register exists.
module program_loader #(
    parameter int unsigned AB   = 11,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StError
    } state_e;

    // Largest legal word count; one more than the address space can hold in AB bits.
    localparam logic [16:0] MaxCount = 17'(1) << AB;

    state_e        state_q, state_d;
    logic [7:0]    cnt_hi_q, cnt_hi_d;
    logic [7:0]    data_hi_q, data_hi_d;
    logic [AB:0]   words_left_q, words_left_d;
    logic [AB-1:0] addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          we_q, we_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    // Full 16-bit count as received, widened so 2^AB can be compared directly.
    logic [16:0] frame_count;
    assign frame_count = {1'b0, cnt_hi_q, bus.rx_data};

    // Next-state logic: byte parser, word assembly, address and status outputs.
    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        data_hi_d    = data_hi_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif

        // Address advances in the cycle after each write pulse; wraps naturally.
        if (we_q) begin
            addr_d = addr_q + {{(AB-1){1'b0}}, 1'b1};
        end

        case (state_q)
            StIdle: begin
                if (bus.rx_valid && (bus.rx_data == SYNC)) begin
                    state_d = StCntHi;
                end
            end
            StCntHi: begin
                if (bus.rx_valid) begin
                    cnt_hi_d = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                    chk_d    = chk_q ^ bus.rx_data;
`endif
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (bus.rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.rx_data;
`endif
                    if (frame_count == 17'd0) begin
                        state_d = StCheck;
                    end else if (frame_count > MaxCount) begin
                        state_d = StError;
                    end else begin
                        words_left_d = frame_count[AB:0];
                        state_d      = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (bus.rx_valid) begin
                    data_hi_d = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = chk_q ^ bus.rx_data;
`endif
                    state_d   = StDataLo;
                end
            end
            StDataLo: begin
                if (bus.rx_valid) begin
                    data_d       = {data_hi_q, bus.rx_data};
                    we_d         = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d        = chk_q ^ bus.rx_data;
`endif
                    words_left_d = words_left_q - {{AB{1'b0}}, 1'b1};
                    if (words_left_q == {{AB{1'b0}}, 1'b1}) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StCheck: begin
`ifdef LOADER_CHECKSUM_EN
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == chk_q) ? StDone : StError;
                end
`else
                state_d = StDone;
`endif
            end
            StDone, StError: begin
                // Written words stay in memory; only the parser is re-armed.
                if (bus.start) begin
                    state_d = StIdle;
                    addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags are registered from the next state so they track state_q.
        hold_d  = (state_d != StDone);
        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_hi_q     <= 8'h00;
            data_hi_q    <= 8'h00;
            words_left_q <= '0;
            addr_q       <= '0;
            data_q       <= 16'h0000;
            we_q         <= 1'b0;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            data_hi_q    <= data_hi_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_we   = we_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames, an expected-write
// scoreboard built from frame contents, and per-cycle output invariants.
module tb_program_loader;

    localparam int unsigned AB = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.AB(AB)) bus ();

    program_loader #(.AB(AB), .SYNC(8'hA5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [AB-1:0] exp_addr_q[$];
    logic [15:0]   exp_data_q[$];
    logic [15:0]   last_data;
    int            wr_count = 0;
    logic [AB-1:0] log_addr[8];
    logic [15:0]   log_data[8];
    logic [AB-1:0] last_wr_addr;
    logic [AB-1:0] ea;
    logic [15:0]   ed;
    logic [15:0]   words[2048];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: writes against the scoreboard, data hold, flag invariants.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = 16'h0000;
        end else begin
            check("hold_vs_done", bus.cpu_hold, !bus.done);
            check("done_error_excl", bus.done & bus.error, 0);
            if (bus.mem_we) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_write", bus.mem_we, 0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    check("wr_addr", bus.mem_addr, ea);
                    check("wr_data", bus.mem_data, ed);
                end
                if (wr_count < 8) begin
                    log_addr[wr_count] = bus.mem_addr;
                    log_data[wr_count] = bus.mem_data;
                end
                last_wr_addr = bus.mem_addr;
                last_data    = bus.mem_data;
                wr_count++;
            end else begin
                check("data_hold", bus.mem_data, last_data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic expect_write(input int idx, input logic [15:0] d);
        exp_addr_q.push_back(AB'(idx));
        exp_data_q.push_back(d);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_data"}, bus.mem_data, 0);
        check({tag, "_we"}, bus.mem_we, 0);
        check({tag, "_hold"}, bus.cpu_hold, 1);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
    endtask

    task automatic wait_end(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.done || bus.error) break;
            idle(1);
        end
        check("end_reached", bus.done | bus.error, 1);
    endtask

    // Sends a full frame of n words from words[], with the XOR checksum byte.
    task automatic load_frame(input int n, input int gap);
        logic [15:0] cnt;
        logic [7:0]  chk;
        cnt = 16'(n);
        chk = cnt[15:8] ^ cnt[7:0];
        for (int i = 0; i < n; i++) begin
            expect_write(i, words[i]);
            chk = chk ^ words[i][15:8] ^ words[i][7:0];
        end
        send_byte(8'hA5);
        idle(gap);
        send_byte(cnt[15:8]);
        idle(gap);
        send_byte(cnt[7:0]);
        idle(gap);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8]);
            idle(gap);
            send_byte(words[i][7:0]);
            idle(gap);
        end
        send_byte(chk);
    endtask

    int base;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        rst_n        = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check_reset_state("rst0");

        // Two-word frame with junk before SYNC
        base = wr_count;
        expect_write(0, 16'h2805);
        expect_write(1, 16'h0801);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h28);
        send_byte(8'h05);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h26);
        wait_end(20);
        idle(1);
        check("a_done", bus.done, 1);
        check("a_hold", bus.cpu_hold, 0);
        check("a_error", bus.error, 0);
        check("a_writes", wr_count - base, 2);
        check("a_log_addr0", log_addr[0], 0);
        check("a_log_data0", log_data[0], 16'h2805);
        check("a_log_addr1", log_addr[1], 1);
        check("a_log_data1", log_data[1], 16'h0801);
        check("a_addr_after", bus.mem_addr, 2);
        check("a_pending", exp_data_q.size(), 0);
        pulse_start();
        check("a_rearm_done", bus.done, 0);
        check("a_rearm_hold", bus.cpu_hold, 1);
        check("a_rearm_addr", bus.mem_addr, 0);

        // Count above 2^AB aborts with no write
        base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h01);
        wait_end(10);
        check("b_error", bus.error, 1);
        check("b_hold", bus.cpu_hold, 1);
        check("b_writes", wr_count - base, 0);
        send_byte(8'hA5);
        idle(2);
        check("b_error_sticky", bus.error, 1);
        pulse_start();
        check("b_rearm_error", bus.error, 0);

        // Zero-word frame
        base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_end(10);
        idle(1);
        check("c_done", bus.done, 1);
        check("c_writes", wr_count - base, 0);
        check("c_addr", bus.mem_addr, 0);
        send_byte(8'hA5);
        idle(2);
        check("c_done_sticky", bus.done, 1);
        pulse_start();

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word written, then error
        base = wr_count;
        expect_write(0, 16'h1234);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        wait_end(10);
        check("d_error", bus.error, 1);
        check("d_hold", bus.cpu_hold, 1);
        check("d_writes", wr_count - base, 1);
        pulse_start();
        check("d_rearm_error", bus.error, 0);
        check("d_rearm_addr", bus.mem_addr, 0);
`endif

        // Reset mid-frame, then a fresh one-word frame with gaps and a stray start
        base = wr_count;
        expect_write(0, 16'h1122);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check_reset_state("rst1");
        check("e_pre_writes", wr_count - base, 1);
        idle(3);
        check("e_no_write_after_rst", wr_count - base, 1);
        expect_write(0, 16'hABCD);
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(1);
        send_byte(8'hAB);
        pulse_start();
        idle(1);
        send_byte(8'hCD);
        idle(2);
        send_byte(8'h67);
        wait_end(10);
        idle(1);
        check("e_done", bus.done, 1);
        check("e_writes", wr_count - base, 2);
        check("e_last_addr", last_wr_addr, 0);
        check("e_pending", exp_data_q.size(), 0);
        pulse_start();

        // Maximal frame, back-to-back bytes
        for (int i = 0; i < 2048; i++) begin
            words[i] = 16'(i * 16'h9E37 + 16'h1234);
        end
        base = wr_count;
        load_frame(2048, 0);
        wait_end(20);
        idle(1);
        check("f_done", bus.done, 1);
        check("f_writes", wr_count - base, 2048);
        check("f_last_addr", last_wr_addr, 11'h7FF);
        check("f_addr_wrap", bus.mem_addr, 0);
        check("f_pending", exp_data_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter AB, default 11, meaning the program-memory address width in bits.
REQ-002 The module SHALL have parameter SYNC, default 8'hA5, meaning the frame-start byte value.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port rx_data  input  8  carries the received byte.
REQ-006 Port rx_valid  input  1  is a one-cycle strobe qualifying rx_data.
REQ-007 Port start  input  1  re-arms the loader from DONE or ERROR.
REQ-008 Port mem_addr  output  AB  is the program-memory write address.
REQ-009 Port mem_data  output  16  is the instruction word, {opcode[15:11], operand[10:0]}.
REQ-010 Port mem_we  output  1  is the program-memory write enable, a one-cycle pulse.
REQ-011 Port cpu_hold  output  1  holds the CPU; it gates the PC write enable while high.
REQ-012 Port done  output  1  means the load completed successfully.
REQ-013 Port error  output  1  means the load was aborted.

Function
REQ-014 Frame format SHALL be: SYNC, COUNT_HI, COUNT_LO, then COUNT words sent as 2 bytes each (MSB first), then CHK.
REQ-015 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-016 Transitions SHALL be:
- IDLE->CNT_HI on rx_valid with rx_data==SYNC.
- Any other byte in IDLE SHALL be ignored.
REQ-017 Transitions SHALL be:
- CNT_HI->CNT_LO on rx_valid.
- CNT_LO->DATA_HI on rx_valid when count is 1 to 2^AB.
- CNT_LO->CHECK when count==0.
- CNT_LO->ERROR when count>2^AB.
REQ-018 Transitions SHALL be DATA_HI->DATA_LO on rx_valid, and DATA_LO->DATA_HI on rx_valid, or DATA_LO->CHECK after the last word.
REQ-019 In DATA_LO on rx_valid, the block SHALL present mem_data={hi_byte, rx_data} with mem_we=1 in the following cycle.
REQ-020 mem_addr SHALL start at 0 and SHALL increment by 1 after each write.
REQ-021 The word counter SHALL be AB+1 bits wide, so that a count of exactly 2^AB is legal.
REQ-022 mem_addr SHALL wrap to 0 after the 2^AB-th write without any extra write.
REQ-023 cpu_hold SHALL be 1 in every state except DONE.
REQ-024 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-025 DONE and ERROR SHALL ignore rx_valid, and SHALL go to IDLE when start==1.
- Going to IDLE SHALL clear mem_addr and the checksum.
REQ-026 start asserted in any state other than DONE or ERROR SHALL be ignored.
REQ-027 rx_valid SHALL be consumed at most once per cycle.
- Cycles without rx_valid SHALL leave the state unchanged.
- There is no timeout.
REQ-028 mem_data SHALL hold its last value when mem_we==0.

Reset
REQ-029 While rst_n==0 at a clock edge, the block SHALL enter IDLE.
REQ-030 While rst_n==0 at a clock edge, the block SHALL drive mem_addr=0, mem_data=0, mem_we=0, cpu_hold=1, done=0, error=0, and clear the counters and the checksum.
REQ-031 Reset mid-frame SHALL discard the partial frame; the block SHALL issue no further write until a new SYNC arrives.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN, when defined, SHALL enable checksum checking.
- The running checksum is the XOR of COUNT_HI, COUNT_LO and all data bytes.
- In CHECK, on rx_valid, the FSM SHALL go to DONE if rx_data==checksum, otherwise to ERROR.
- Words already written remain in memory.
REQ-033 When LOADER_CHECKSUM_EN is undefined, no CHK byte is expected.
- CHECK SHALL pass unconditionally to DONE in the next cycle.
- No checksum register SHALL be synthesized.

Verification
REQ-034 Send bytes 00,13,A5,00,02,28,05,08,01,XOR.
- Required: exactly two writes, addr0=16'h2805 and addr1=16'h0801.
- Required: done=1, cpu_hold=0.
REQ-035 (LOADER_CHECKSUM_EN defined) Send A5,00,01,12,34, then CHK=8'h00.
- Required: 1 write, then error=1 and cpu_hold=1.
- Then pulse start: required IDLE, error=0.
REQ-036 Send A5,08,01 with AB=11.
- Required: ERROR, and no mem_we pulse.
REQ-037 Send A5,00,00, then CHK 00.
- Required: DONE with zero writes and mem_addr=0.
REQ-038 Send A5,00,03,11,22,33, then pull rst_n low for 1 cycle, then send a full 1-word frame.
- Required: the reset defaults listed above.
- Required: the single new word lands at addr 0.
REQ-039 Load the maximal frame (count=2048) with rx_valid on every cycle.
- Required: 2048 writes, the last at addr 11'h7FF.
- Required: mem_addr wraps to 0, then done=1.
